shift_scheduler: RTL and testbench
==================================

SHIFT_SCHEDULER -- requirements
Module: shift_scheduler

Interface
REQ-001 SHALL take parameter TAG_W, default core_config_pkg::SHIFT_TAG_W (=5), the width of the opaque result tag.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port flush, input, 1, synchronous pipeline kill.
REQ-005 SHALL have ports req_valid and req_ready, input and output, [1:0], per-requester valid/ready handshake.
REQ-006 SHALL have port req_data, input, [1:0][XLEN-1:0], operands.
REQ-007 SHALL have port req_amount, input, [1:0][$clog2(XLEN)-1:0], shift amounts.
REQ-008 SHALL have ports req_left and req_arith, input, [1:0], direction and arithmetic flags (arith ignored when left=1).
REQ-009 SHALL have port req_tag, input, [1:0][TAG_W-1:0], tags.
REQ-010 SHALL have ports res_valid and res_ready, output and input, 1, result handshake.
REQ-011 SHALL have ports res_data (output, XLEN), res_tag (output, TAG_W) and res_src (output, 1, index of the granted requester).
REQ-012 SHALL have port busy, output, 1, high whenever state != IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, START, WAIT, RESULT, DRAIN.
REQ-014 In IDLE with flush=0, req_ready[i] SHALL equal grant[i]; in every other state and when flush=1, req_ready SHALL be 2'b00.
REQ-015 Arbitration SHALL be round-robin: single valid wins; if both are valid, the requester not granted last wins; last_grant resets to 1 so requester 0 wins first.
REQ-016 On handshake, operand/amount/flags/tag/src SHALL be latched, last_grant updated, and the FSM SHALL go to START.
REQ-017 START SHALL last exactly 1 cycle, assert the shifter start with the latched operands, then go to WAIT.
REQ-018 The shifter done level SHALL be sampled only in WAIT and DRAIN; a stale done in START SHALL be ignored.
REQ-019 In WAIT with done=1, res_data SHALL be captured from the shifter output and the FSM SHALL go to RESULT.
REQ-020 Latency: res_valid SHALL rise ceil(n/MAX_SHIFT_PER_CYCLE)+4 cycles after the handshake edge (n=amount; MAX_SHIFT_PER_CYCLE=3 gives n=0 -> 4, n=31 -> 15).
REQ-021 In RESULT, res_valid=1 and res_data/res_tag/res_src SHALL be held stable until res_ready=1, then the FSM SHALL go to IDLE; no new request is accepted in that cycle.
REQ-022 flush in START or WAIT SHALL go to DRAIN; DRAIN SHALL wait for shifter done=1, then go to IDLE with no result.
REQ-023 flush in RESULT SHALL drop res_valid the next cycle and go to IDLE.
REQ-024 flush in DRAIN or IDLE SHALL have no effect other than REQ-014.
REQ-025 flush and res_ready in the same RESULT cycle SHALL count as result consumed (IDLE next).
REQ-026 res_valid SHALL be 0 in every state except RESULT.

Reset
REQ-027 On rst_n=0 the block SHALL asynchronously enter IDLE with res_valid=0, res_data=0, res_tag=0, res_src=0, busy=0, last_grant=1 and all latches cleared; the shifter SHALL share rst_n.
REQ-028 Reset mid-operation SHALL abort with no result and leave the block ready in the first cycle after release.

Structure
REQ-029 The state enum shift_sched_state_t and the constant SHIFT_TAG_W SHALL live in core_config_pkg; MAX_SHIFT_PER_CYCLE SHALL be reused from it.
REQ-030 The block SHALL instantiate exactly one existing shift module as its sole sub-module; arbitration and FSM SHALL be local.

Verification
REQ-031 Single op: req0 data=0x0000_00F0, amount=4, left=1, tag=3 -> res_data=0x0000_0F00, tag=3, src=0, res_valid 6 cycles after handshake.
REQ-032 Contention: both valid every cycle, back-to-back -> grants alternate 0,1,0,1; each res_src/res_tag matches its requester; no request is lost.
REQ-033 Arithmetic and boundaries: data=0x8000_0000, arith=1, amount=31 -> 0xFFFF_FFFF at latency 15; amount=0 -> data returned unchanged at latency 4.
REQ-034 Backpressure: res_ready=0 for 10 cycles -> res_valid and outputs stable throughout, req_ready=00; the result is accepted on the first res_ready=1.
REQ-035 Flush in WAIT (amount=20) -> no res_valid; busy stays high until shifter done, then IDLE; the next request completes correctly.
REQ-036 rst_n pulse during WAIT -> all outputs zero immediately; a request issued after release completes with normal latency.

Source files
------------

// File: rtl/core_config_pkg.sv
// Shared core configuration: datapath widths, shift engine rate and the
// scheduler / shifter state encodings.
package core_config_pkg;

   localparam int unsigned XLEN                = 32;
   localparam int unsigned AMT_W               = $clog2(XLEN);
   localparam int unsigned SHIFT_TAG_W         = 5;
   localparam int unsigned MAX_SHIFT_PER_CYCLE = 3;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      RESULT,
      DRAIN
   } shift_sched_state_t;

   typedef enum logic [1:0] {
      SH_IDLE,
      SH_RUN,
      SH_FIN
   } shifter_phase_t;

   typedef struct packed {
      logic [XLEN-1:0]  data;
      logic [AMT_W-1:0] amount;
      logic             left;
      logic             arith;
   } shift_op_t;

   // One partial shift step; arith only matters for right shifts.
   function automatic logic [XLEN-1:0] shift_step(
      input logic [XLEN-1:0]  a,
      input logic [AMT_W-1:0] s,
      input logic             left,
      input logic             arith
   );
      if (left) begin
         return a << s;
      end
      if (arith) begin
         return $unsigned($signed(a) >>> s);
      end
      return a >> s;
   endfunction

endpackage

// File: rtl/shift_scheduler_shifter.sv
// Multi-cycle shifter: moves at most MAX_SHIFT_PER_CYCLE bit positions per
// clock, then registers the result and holds done high until the next start.
module shift_scheduler_shifter
   import core_config_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  shift_op_t       op,
   output logic            done,
   output logic [XLEN-1:0] result
);

   shifter_phase_t   phase;
   logic [XLEN-1:0]  acc;
   logic [AMT_W-1:0] remain;
   logic [AMT_W-1:0] step;
   logic             left_q;
   logic             arith_q;

   // Clamp this cycle's step to the per-cycle shift budget.
   always_comb begin
      step = remain;
      if (remain > AMT_W'(MAX_SHIFT_PER_CYCLE)) begin
         step = AMT_W'(MAX_SHIFT_PER_CYCLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase   <= SH_IDLE;
         acc     <= '0;
         remain  <= '0;
         left_q  <= 1'b0;
         arith_q <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
      end else if (start) begin
         phase   <= SH_RUN;
         acc     <= op.data;
         remain  <= op.amount;
         left_q  <= op.left;
         arith_q <= op.arith;
         done    <= 1'b0;
      end else begin
         case (phase)
            SH_RUN: begin
               if (remain == '0) begin
                  phase <= SH_FIN;
               end else begin
                  acc    <= shift_step(acc, step, left_q, arith_q);
                  remain <= remain - step;
               end
            end
            SH_FIN: begin
               result <= acc;
               done   <= 1'b1;
               phase  <= SH_IDLE;
            end
            SH_IDLE: begin
               phase <= SH_IDLE;
            end
            default: begin
               phase <= SH_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/shift_scheduler.sv
// Two-requester round-robin front end for the multi-cycle shifter, with a
// flushable single-outstanding-operation pipeline and a held result port.
module shift_scheduler
   import core_config_pkg::*;
#(
   parameter int unsigned TAG_W = SHIFT_TAG_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic [1:0]                  req_valid,
   output logic [1:0]                  req_ready,
   input  logic [1:0][XLEN-1:0]        req_data,
   input  logic [1:0][AMT_W-1:0]       req_amount,
   input  logic [1:0]                  req_left,
   input  logic [1:0]                  req_arith,
   input  logic [1:0][TAG_W-1:0]       req_tag,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [XLEN-1:0]             res_data,
   output logic [TAG_W-1:0]            res_tag,
   output logic                        res_src,
   output logic                        busy
);

   shift_sched_state_t state;
   shift_op_t          op_q;
   logic [TAG_W-1:0]   tag_q;
   logic               src_q;
   logic               last_grant;
   logic [1:0]         grant;
   logic               sel;
   logic               accept;
   logic               sh_start;
   logic               sh_done;
   logic [XLEN-1:0]    sh_result;

   // Round-robin: a lone requester wins; on contention the one not served last.
   always_comb begin
      grant = 2'b00;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_comb begin
      req_ready = 2'b00;
      if ((state == IDLE) && !flush) begin
         req_ready = grant;
      end
   end

   assign sel      = grant[1];
   assign accept   = |(req_valid & req_ready);
   assign sh_start = (state == START);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         op_q       <= '0;
         tag_q      <= '0;
         src_q      <= 1'b0;
         last_grant <= 1'b1;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_tag    <= '0;
         res_src    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q.data   <= req_data[sel];
                  op_q.amount <= req_amount[sel];
                  op_q.left   <= req_left[sel];
                  op_q.arith  <= req_arith[sel];
                  tag_q       <= req_tag[sel];
                  src_q       <= sel;
                  last_grant  <= sel;
                  busy        <= 1'b1;
                  state       <= START;
               end
            end
            // The shifter clears its previous done on this start, so START never samples it.
            START: begin
               state <= flush ? DRAIN : WAIT;
            end
            WAIT: begin
               if (flush) begin
                  state <= DRAIN;
               end else if (sh_done) begin
                  res_data  <= sh_result;
                  res_tag   <= tag_q;
                  res_src   <= src_q;
                  res_valid <= 1'b1;
                  state     <= RESULT;
               end
            end
            RESULT: begin
               if (res_ready || flush) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            // Killed operation: let the shifter finish so its done is known fresh.
            DRAIN: begin
               if (sh_done) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               res_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   shift_scheduler_shifter u_shifter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (sh_start),
      .op     (op_q),
      .done   (sh_done),
      .result (sh_result)
   );

endmodule

// File: tb/tb_shift_scheduler.sv
// Directed bench for shift_scheduler: single ops, boundaries, contention,
// backpressure, flush and mid-operation reset.
module tb_shift_scheduler;
   import core_config_pkg::*;

   localparam int unsigned TW = SHIFT_TAG_W;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  flush = 1'b0;
   logic [1:0]            req_valid = '0;
   logic [1:0]            req_ready;
   logic [1:0][XLEN-1:0]  req_data = '0;
   logic [1:0][AMT_W-1:0] req_amount = '0;
   logic [1:0]            req_left = '0;
   logic [1:0]            req_arith = '0;
   logic [1:0][TW-1:0]    req_tag = '0;
   logic                  res_valid;
   logic                  res_ready = 1'b0;
   logic [XLEN-1:0]       res_data;
   logic [TW-1:0]         res_tag;
   logic                  res_src;
   logic                  busy;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic            r;
      logic [XLEN-1:0] d;
      logic [4:0]      a;
      logic            l;
      logic            ar;
      logic [4:0]      t;
      logic [XLEN-1:0] e;
      int              lat;
   } vec_t;

   vec_t vecs[7];

   shift_scheduler #(.TAG_W(TW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .req_amount (req_amount),
      .req_left   (req_left),
      .req_arith  (req_arith),
      .req_tag    (req_tag),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_tag    (res_tag),
      .res_src    (res_src),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request and return just after the handshake edge.
   task automatic issue(input logic r, input logic [XLEN-1:0] d, input logic [4:0] a,
                        input logic l, input logic ar, input logic [4:0] t);
      logic hs;
      req_valid     = 2'b00;
      req_valid[r]  = 1'b1;
      req_data[r]   = d;
      req_amount[r] = a;
      req_left[r]   = l;
      req_arith[r]  = ar;
      req_tag[r]    = t;
      hs = 1'b0;
      for (int i = 0; i < 50 && !hs; i++) begin
         #1;
         hs = req_ready[r];
         @(posedge clk);
         #1;
      end
      req_valid = 2'b00;
      check("handshake", 64'(hs), 64'(1));
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!res_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic consume();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("consume_valid", 64'(res_valid), 64'(0));
      check("consume_busy", 64'(busy), 64'(0));
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int lat;
      int n;
      int e;
      logic seen;
      logic [XLEN-1:0] held;

      vecs[0] = '{1'b0, 32'h0000_00F0, 5'd4,  1'b1, 1'b0, 5'd3, 32'h0000_0F00, 6};
      vecs[1] = '{1'b0, 32'h8000_0000, 5'd31, 1'b0, 1'b1, 5'd4, 32'hFFFF_FFFF, 15};
      vecs[2] = '{1'b1, 32'h1234_5678, 5'd0,  1'b0, 1'b1, 5'd5, 32'h1234_5678, 4};
      vecs[3] = '{1'b0, 32'h8000_0000, 5'd31, 1'b0, 1'b0, 5'd6, 32'h0000_0001, 15};
      vecs[4] = '{1'b1, 32'h0000_0003, 5'd31, 1'b1, 1'b0, 5'd7, 32'h8000_0000, 15};
      vecs[5] = '{1'b0, 32'h8000_00F0, 5'd4,  1'b1, 1'b1, 5'd8, 32'h0000_0F00, 6};
      vecs[6] = '{1'b1, 32'hF000_000F, 5'd5,  1'b0, 1'b0, 5'd9, 32'h0780_0000, 6};

      tick();
      check("rst_valid", 64'(res_valid), 64'(0));
      check("rst_data", 64'(res_data), 64'(0));
      check("rst_tag", 64'(res_tag), 64'(0));
      check("rst_src", 64'(res_src), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      tick();
      rst_n = 1'b1;
      tick();
      req_valid = 2'b11;
      #1;
      check("rr_first_grant", 64'(req_ready), 64'(2'b01));
      req_valid = 2'b00;

      // Directed single operations.
      foreach (vecs[i]) begin
         issue(vecs[i].r, vecs[i].d, vecs[i].a, vecs[i].l, vecs[i].ar, vecs[i].t);
         wait_result(lat);
         check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
         check($sformatf("v%0d_data", i), 64'(res_data), 64'(vecs[i].e));
         check($sformatf("v%0d_tag", i), 64'(res_tag), 64'(vecs[i].t));
         check($sformatf("v%0d_src", i), 64'(res_src), 64'(vecs[i].r));
         check($sformatf("v%0d_busy", i), 64'(busy), 64'(1));
         consume();
      end

      // Backpressure: result held for 10 cycles with both requesters waiting.
      issue(1'b1, 32'h0000_1234, 5'd8, 1'b1, 1'b0, 5'h1F);
      wait_result(lat);
      check("bp_lat", 64'(lat), 64'(7));
      held = res_data;
      check("bp_data", 64'(held), 64'(32'h0012_3400));
      req_valid = 2'b11;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("bp_valid", 64'(res_valid), 64'(1));
         check("bp_hold", 64'(res_data), 64'(32'h0012_3400));
         check("bp_tag", 64'(res_tag), 64'(5'h1F));
         check("bp_src", 64'(res_src), 64'(1));
         check("bp_ready", 64'(req_ready), 64'(2'b00));
      end
      req_valid = 2'b00;
      consume();

      // Contention: both valid continuously, grants alternate from requester 0.
      reset_dut();
      req_data[0] = 32'h0000_0001; req_amount[0] = 5'd1; req_left[0] = 1'b1;
      req_arith[0] = 1'b0;         req_tag[0] = 5'h0A;
      req_data[1] = 32'h0000_0100; req_amount[1] = 5'd2; req_left[1] = 1'b0;
      req_arith[1] = 1'b0;         req_tag[1] = 5'h15;
      res_ready = 1'b1;
      req_valid = 2'b11;
      n = 0;
      e = 0;
      while (n < 4 && e < 200) begin
         tick();
         e++;
         if (res_valid) begin
            check("ctn_src", 64'(res_src), 64'(n % 2));
            check("ctn_tag", 64'(res_tag), (n % 2 == 1) ? 64'(5'h15) : 64'(5'h0A));
            check("ctn_data", 64'(res_data), (n % 2 == 1) ? 64'(32'h40) : 64'(32'h2));
            n++;
            if (n == 4) req_valid = 2'b00;
         end
      end
      check("ctn_count", 64'(n), 64'(4));
      tick();
      res_ready = 1'b0;
      check("ctn_idle", 64'(busy), 64'(0));

      // Flush in RESULT drops the result; flush in IDLE masks req_ready.
      issue(1'b0, 32'h0000_00A5, 5'd0, 1'b0, 1'b0, 5'd7);
      wait_result(lat);
      check("fr_lat", 64'(lat), 64'(4));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fr_valid", 64'(res_valid), 64'(0));
      check("fr_busy", 64'(busy), 64'(0));
      flush = 1'b1;
      req_valid = 2'b01;
      #1;
      check("fi_ready", 64'(req_ready), 64'(2'b00));
      flush = 1'b0;
      #1;
      check("fi_ready_off", 64'(req_ready), 64'(2'b01));
      req_valid = 2'b00;

      // Flush in WAIT: drain until the shifter finishes, no result.
      issue(1'b0, 32'h0000_0001, 5'd20, 1'b1, 1'b0, 5'd2);
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      e = 3;
      seen = 1'b0;
      while (busy && e < 60) begin
         seen = seen | res_valid;
         tick();
         e++;
      end
      check("fw_no_valid", 64'(seen | res_valid), 64'(0));
      check("fw_drain_edges", 64'(e), 64'(11));
      issue(1'b0, 32'h0000_0001, 5'd5, 1'b1, 1'b0, 5'd11);
      wait_result(lat);
      check("fw_next_lat", 64'(lat), 64'(6));
      check("fw_next_data", 64'(res_data), 64'(32'h20));
      check("fw_next_tag", 64'(res_tag), 64'(5'd11));
      consume();

      // Reset pulse during WAIT.
      issue(1'b1, 32'h0000_0001, 5'd10, 1'b1, 1'b0, 5'd9);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("ar_valid", 64'(res_valid), 64'(0));
      check("ar_data", 64'(res_data), 64'(0));
      check("ar_tag", 64'(res_tag), 64'(0));
      check("ar_busy", 64'(busy), 64'(0));
      #2;
      rst_n = 1'b1;
      req_valid = 2'b01;
      #1;
      check("ar_ready", 64'(req_ready), 64'(2'b01));
      issue(1'b0, 32'h0000_0001, 5'd7, 1'b1, 1'b0, 5'd13);
      wait_result(lat);
      check("ar_next_lat", 64'(lat), 64'(7));
      check("ar_next_data", 64'(res_data), 64'(32'h80));
      check("ar_next_src", 64'(res_src), 64'(0));
      consume();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
